instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch-side initiator for the instruction memory. Owns the fetch PC and drives the byte address into the combinational instruction memory.
- Captures each returned word, together with its PC, into a small FIFO. Decode drains the FIFO over a valid/ready handshake.
- Handles redirects (branch/jump targets from execute): flushes the buffer and restarts fetch at the target.
- Sits between the instruction memory and the decode stage.

Parameters:
- WORD_SIZE, 32, width of addresses, PCs and instruction words.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- FIFO_DEPTH, 2, number of buffered {pc, instr} entries; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  WORD_SIZE  byte address to the instruction memory; equals fetch_pc combinationally.
- imem_instr  input  WORD_SIZE  word returned by the memory in the same cycle (zero-latency read).
- redirect_valid  input  1  one-cycle request to restart fetch.
- redirect_pc  input  WORD_SIZE  restart target byte address.
- out_valid  output  1  FIFO head holds a valid instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_instr  output  WORD_SIZE  instruction word at the FIFO head.
- out_pc  output  WORD_SIZE  byte address of out_instr.
- fetch_err  output  1  sticky flag: a misaligned redirect target was received.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (rst). Nothing is reset asynchronously.
- Reset values: fetch_pc=RESET_PC, FIFO count=0, out_valid=0, out_instr=0, out_pc=0, fetch_err=0, state=RUN.
- Pop: occurs when out_valid && out_ready. The head advances at the clock edge.
- Push (state RUN, no redirect): when count<FIFO_DEPTH, or when the FIFO is full and a pop happens in the same cycle.
  - Push writes {fetch_pc, imem_instr} at the tail.
  - fetch_pc <= fetch_pc+4, modulo 2^WORD_SIZE (32'hFFFF_FFFC wraps to 0).
- Full with no pop: no push, fetch_pc holds, imem_addr stable.
- Latency: the first instruction is visible (out_valid=1, out_pc=RESET_PC) in the first cycle after rst deasserts plus one edge. After that, one instruction per cycle while out_ready=1.
- out_instr and out_pc hold while out_valid=1 and out_ready=0.
- Redirect has priority over push and pop in the same cycle:
  - the FIFO is flushed (count=0);
  - the popped head counts as not consumed;
  - fetch_pc <= redirect_pc;
  - out_valid=0 on the next cycle;
  - the target instruction appears one cycle later.
- Misaligned redirect (redirect_pc[1:0] != 0):
  - fetch_err <= 1 (sticky until rst);
  - FIFO flushed, state <= HALT;
  - fetch_pc is not loaded.
- State machine:
  - RUN: normal fetch.
  - HALT: no pushes. imem_addr holds the last fetch_pc. out_valid=0. Redirects ignored. Exit only via rst.
- A redirect arriving when the FIFO is empty behaves identically to the non-empty case.
- rst mid-stream: overrides everything in that cycle. All in-flight entries are lost.
- Width rules: PC arithmetic is unsigned WORD_SIZE. Only bits [WORD_SIZE-1:2] are meaningful to memory. fetch_pc[1:0] is always 0 in RUN.

Decomposition:
- Shared package riscv_pkg holds:
  - WORD_SIZE;
  - RESET_PC;
  - PC_STEP=4;
  - the fetch_state_t enum {RUN, HALT};
  - a fetch_entry_t struct {pc, instr}.
- One sub-module, fetch_fifo: a synchronous FIFO with push, pop and flush. Flush takes priority over push and pop. It exposes count, full and empty.
- PC register, redirect logic and FSM stay in instr_fetch_unit.

Test Plan:
- Streaming:
  - Setup: memory words 0..3 = 00500093, 00A00113, 002081B3, 00000013; out_ready=1.
  - Stimulus: release rst.
  - Expected: out_pc sequence 0,4,8,C on consecutive cycles with the matching out_instr; fetch_err=0.
- Backpressure:
  - Stimulus: out_ready=0 after reset for 5 cycles.
  - Expected: count reaches 2; imem_addr holds 8; out_pc=0 stable.
  - Then out_ready=1: pcs 0,4,8 emerge with no gaps or duplicates.
- Redirect with full FIFO and simultaneous pop:
  - Stimulus: redirect_pc=0x40 while out_ready=1.
  - Expected: next cycle out_valid=0; following cycle out_pc=0x40 with instr=mem[16].
- Misaligned redirect:
  - Stimulus: redirect_pc=0x42.
  - Expected: fetch_err=1, out_valid=0 permanently; a later redirect to 0x40 is ignored.
  - rst clears fetch_err and restarts at 0.
- Wrap-around:
  - Stimulus: redirect_pc=32'hFFFF_FFFC.
  - Expected: out_pc FFFF_FFFC followed by 0000_0000.
- Reset mid-operation:
  - Stimulus: assert rst for one cycle with 2 entries buffered and out_ready=0.
  - Expected: out_valid=0 the next cycle; stream restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants: word width, reset PC, PC step,
// fetch FSM states and the buffered {pc, instr} entry.
package riscv_pkg;

  localparam int WORD_SIZE = 32;
  localparam logic [WORD_SIZE-1:0] RESET_PC = 32'h0000_0000;
  localparam int PC_STEP = 4;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with push, pop and flush; flush beats both.
// Head is read combinationally so decode sees a new entry the cycle after it lands.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             din,
  input  logic                     pop,
  output fetch_entry_t             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;
  fetch_entry_t  slot_q [DEPTH];

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO may still accept a push when its head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      fetch_entry_t slot_reg;
      always_ff @(posedge clk) begin
        if (do_push && wr_ptr_reg == AW'(gi)) begin
          slot_reg <= din;
        end
      end
      assign slot_q[gi] = slot_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = slot_q[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch PC, redirect handling and RUN/HALT control in front of a zero-latency
// instruction memory; fetched {pc, instr} pairs are buffered for decode.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int                          WORD_SIZE  = riscv_pkg::WORD_SIZE,
  parameter logic [riscv_pkg::WORD_SIZE-1:0] RESET_PC = riscv_pkg::RESET_PC,
  parameter int                          FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [WORD_SIZE-1:0] imem_addr,
  input  logic [WORD_SIZE-1:0] imem_instr,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_instr,
  output logic [WORD_SIZE-1:0] out_pc,
  output logic                 fetch_err
);

  fetch_state_t                  state_reg, state_next;
  logic [WORD_SIZE-1:0]          fetch_pc_reg, fetch_pc_next;
  logic                          err_reg, err_next;
  logic                          push_en, flush_en, pop;
  logic                          fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          count_unused;
  fetch_entry_t                  fifo_head;
  fetch_entry_t                  push_entry;

  assign pop        = out_valid && out_ready;
  assign push_entry = {fetch_pc_reg, imem_instr};

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    err_next      = err_reg;
    push_en       = 1'b0;
    flush_en      = 1'b0;
    case (state_reg)
      RUN: begin
        if (redirect_valid) begin
          flush_en = 1'b1;
          // A misaligned target is fatal: keep the old PC and stop fetching.
          if (redirect_pc[1:0] != 2'b00) begin
            err_next   = 1'b1;
            state_next = HALT;
          end else begin
            fetch_pc_next = redirect_pc;
          end
        end else if (!fifo_full || pop) begin
          push_en       = 1'b1;
          fetch_pc_next = fetch_pc_reg + WORD_SIZE'(PC_STEP);
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RUN;
      fetch_pc_reg <= RESET_PC;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      err_reg      <= err_next;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_en),
    .push  (push_en),
    .din   (push_entry),
    .pop   (pop),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Occupancy is not needed by the fetch control; it stays wired for debug visibility.
  assign count_unused = ^fifo_count;

  assign imem_addr = fetch_pc_reg;
  assign out_valid = (state_reg == RUN) && !fifo_empty;
  assign out_pc    = out_valid ? fifo_head.pc    : '0;
  assign out_instr = out_valid ? fifo_head.instr : '0;
  assign fetch_err = err_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a vector table for streaming/redirect/
// misalignment/wrap, plus hand sequences for backpressure and mid-stream reset.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fetch_err;

  int tests;
  int failed;

  logic [31:0] rom [64];

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fetch_err      (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_instr = rom[imem_addr[7:2]];

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_addr;
    logic        e_err;
  } vec_t;

  vec_t vecs [21];

  function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rpc,
                              input logic rdy, input logic ev, input logic [31:0] epc,
                              input logic [31:0] ea, input logic ee);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.e_valid = ev; v.e_pc = epc; v.e_addr = ea; v.e_err = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    failed = 0;
    for (int i = 0; i < 64; i++) rom[i] = 32'hA500_0000 | 32'(i);
    rom[0] = 32'h0050_0093;
    rom[1] = 32'h00A0_0113;
    rom[2] = 32'h0020_81B3;
    rom[3] = 32'h0000_0013;

    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b1;

    //            rst   rv    rpc           rdy   valid pc            addr          err
    vecs[0]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        1'b0);
    vecs[1]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'h4,        1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        32'h8,        1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        32'hC,        1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hC,        32'h10,       1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hC,        32'h14,       1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hC,        32'h14,       1'b0);
    vecs[7]  = mk(1'b0, 1'b1, 32'h40,       1'b1, 1'b0, 32'h0,        32'h40,       1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h40,       32'h44,       1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h44,       32'h48,       1'b0);
    vecs[10] = mk(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,       32'hFFFF_FFFC, 1'b0);
    vecs[11] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0,       1'b0);
    vecs[12] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'h4,        1'b0);
    vecs[13] = mk(1'b0, 1'b1, 32'h80,       1'b1, 1'b0, 32'h0,        32'h80,       1'b0);
    vecs[14] = mk(1'b0, 1'b1, 32'h20,       1'b1, 1'b0, 32'h0,        32'h20,       1'b0);
    vecs[15] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h20,       32'h24,       1'b0);
    vecs[16] = mk(1'b0, 1'b1, 32'h42,       1'b1, 1'b0, 32'h0,        32'h24,       1'b1);
    vecs[17] = mk(1'b0, 1'b1, 32'h40,       1'b1, 1'b0, 32'h0,        32'h24,       1'b1);
    vecs[18] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h24,       1'b1);
    vecs[19] = mk(1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        1'b0);
    vecs[20] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'h4,        1'b0);

    for (int i = 0; i < 21; i++) begin
      rst            = vecs[i].rst;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      out_ready      = vecs[i].rdy;
      tick();
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
      check($sformatf("v%0d_err", i), 32'(fetch_err), 32'(vecs[i].e_err));
      if (vecs[i].e_valid || vecs[i].rst) begin
        check($sformatf("v%0d_pc", i), out_pc, vecs[i].e_pc);
        check($sformatf("v%0d_instr", i), out_instr,
              vecs[i].e_valid ? rom[vecs[i].e_pc[7:2]] : 32'h0);
      end
    end
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;

    // Backpressure: buffer fills to two entries, then drains without gaps.
    rst = 1'b1;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    check("bp_reset_count", 32'(dut.u_fifo.count), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("bp%0d_count", k), 32'(dut.u_fifo.count), (k < 2) ? 32'(k) : 32'd2);
      check($sformatf("bp%0d_addr", k), imem_addr, (k < 2) ? 32'(4 * k) : 32'h8);
      check($sformatf("bp%0d_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_pc", k), out_pc, 32'h0);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("drain%0d_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("drain%0d_pc", k), out_pc, 32'(4 * k));
      check($sformatf("drain%0d_instr", k), out_instr, rom[k]);
      tick();
    end

    // Reset with two entries buffered and decode stalled.
    out_ready = 1'b0;
    tick();
    tick();
    check("mid_full_count", 32'(dut.u_fifo.count), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_addr", imem_addr, 32'h0);
    check("mid_rst_count", 32'(dut.u_fifo.count), 32'd0);
    tick();
    check("mid_restart_valid", 32'(out_valid), 32'd1);
    check("mid_restart_pc", out_pc, 32'h0);
    check("mid_restart_instr", out_instr, rom[0]);
    check("mid_restart_addr", imem_addr, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
